// File: rtl/selevy_gpin.sv
// selevy general-purpose input port: synchronizes an external nibble and its
// strobe into the CLK domain and queues one sample per strobe rising edge.
module selevy_gpin #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] gin,
  input  logic             in_clk,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovf
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // synchronizer and edge-detect history
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] g2_q, g2_d;

  // FIFO state
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic cap;
  logic push;
  logic pop;
  logic drop;

  always_comb begin
    s1_d     = in_clk;
    s2_d     = s1_q;
    s3_d     = s2_q;
    g1_d     = gin;
    g2_d     = g1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    mem_d    = mem_q;

    cap  = s2_q & ~s3_q;
    pop  = rd_en & (count_q != '0);
    // a pop on the same edge frees the slot, so a full FIFO can still accept
    push = cap & ((count_q != CNT_FULL) | pop);
    drop = cap & ~push;

    if (push) begin
      mem_d[wr_ptr_q] = g2_q;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      hold_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // a new drop outranks a clear on the same edge
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      g1_q     <= '0;
      g2_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      g1_q     <= g1_d;
      g2_q     <= g2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // when empty, the last popped value stays visible
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign rd_data = empty ? hold_q : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_selevy_gpin.sv
// Bench for selevy_gpin: directed plan plus random strobes, checked against a
// queue-based reference model and a read scoreboard.
module tb_selevy_gpin;

  localparam int W = 4;
  localparam int D = 4;
  localparam int A = 2;

  logic         CLK = 1'b0;
  logic         reset;
  logic [W-1:0] gin;
  logic         in_clk;
  logic         rd_en;
  logic         ovf_clr;
  logic [W-1:0] rd_data;
  logic         empty;
  logic         full;
  logic [A:0]   count;
  logic         ovf;

  selevy_gpin #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .gin     (gin),
    .in_clk  (in_clk),
    .rd_en   (rd_en),
    .ovf_clr (ovf_clr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: FIFO contents, sticky flag, last popped value,
  // and captures scheduled two edges after the strobe is first sampled
  logic [W-1:0] mdl_q[$];
  logic [W-1:0] exp_q[$];
  int           cap_edge_q[$];
  logic [W-1:0] cap_val_q[$];
  logic         mdl_ovf  = 1'b0;
  logic [W-1:0] last_pop = '0;
  logic         prev_in  = 1'b0;
  logic         rnd_rd   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  // read scoreboard: every accepted pop must deliver the next expected value
  always @(posedge CLK) begin
    if (!reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_extra cyc=%0d got=%0h want=none", cyc, rd_data);
      end else begin
        check("pop_rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_state();
    check("count", int'(count), mdl_q.size());
    check("empty", int'(empty), int'(mdl_q.size() == 0));
    check("full",  int'(full),  int'(mdl_q.size() == D));
    check("ovf",   int'(ovf),   int'(mdl_ovf));
    check("rd_data", int'(rd_data),
          int'((mdl_q.size() > 0) ? mdl_q[0] : last_pop));
  endtask

  // one CLK cycle: apply inputs, advance the model for the coming edge, check
  task automatic tick(input logic rd, input logic clr);
    int           e;
    logic         do_cap;
    logic         drop;
    logic [W-1:0] cv;
    rd_en   = rd;
    ovf_clr = clr;
    e       = cyc + 1;
    cv      = '0;
    if (reset) begin
      mdl_q.delete();
      exp_q.delete();
      cap_edge_q.delete();
      cap_val_q.delete();
      mdl_ovf  = 1'b0;
      last_pop = '0;
      prev_in  = 1'b0;
    end else begin
      if (in_clk && !prev_in) begin
        cap_edge_q.push_back(e + 2);
        cap_val_q.push_back(gin);
      end
      prev_in = in_clk;
      do_cap  = (cap_edge_q.size() > 0) && (cap_edge_q[0] == e);
      if (do_cap) begin
        void'(cap_edge_q.pop_front());
        cv = cap_val_q.pop_front();
      end
      if (rd && mdl_q.size() > 0) last_pop = mdl_q.pop_front();
      drop = 1'b0;
      if (do_cap) begin
        if (mdl_q.size() < D) begin
          mdl_q.push_back(cv);
          exp_q.push_back(cv);
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) mdl_ovf = 1'b1;
      else if (clr) mdl_ovf = 1'b0;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    check_state();
  endtask

  function automatic logic rr();
    return rnd_rd ? ($urandom_range(0, 5) == 0) : 1'b0;
  endfunction

  function automatic logic rc();
    return rnd_rd ? ($urandom_range(0, 9) == 0) : 1'b0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(rr(), rc());
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  // strobe one sample; rd_cap/clr_cap land on the capture edge when hi >= 3
  task automatic pulse(input logic [W-1:0] v, input int hi,
                       input logic rd_cap, input logic clr_cap);
    gin = v;
    idle(2);
    in_clk = 1'b1;
    for (int i = 0; i < hi; i++) begin
      if (i == 2) tick(rd_cap | rr(), clr_cap | rc());
      else        tick(rr(), rc());
    end
    in_clk = 1'b0;
    idle(3);
  endtask

  initial begin
    reset   = 1'b1;
    gin     = '0;
    in_clk  = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    @(negedge CLK);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
    idle(10);

    // single long strobe: exactly one capture
    pulse(4'hA, 8, 1'b0, 1'b0);
    in_clk = 1'b1;
    idle(6);
    in_clk = 1'b0;
    idle(3);
    drain(1);

    // fill, drain, then reads while empty
    pulse(4'hA, 3, 1'b0, 1'b0);
    pulse(4'hB, 3, 1'b0, 1'b0);
    pulse(4'hC, 3, 1'b0, 1'b0);
    pulse(4'hD, 3, 1'b0, 1'b0);
    drain(4);
    drain(2);

    // overflow, clear, then overflow together with clear
    for (int i = 1; i <= 4; i++) pulse(W'(i), 3, 1'b0, 1'b0);
    pulse(4'h5, 3, 1'b0, 1'b0);
    tick(1'b0, 1'b1);
    pulse(4'h7, 3, 1'b0, 1'b1);
    tick(1'b0, 1'b1);
    drain(4);

    // full plus simultaneous push and pop
    for (int i = 1; i <= 4; i++) pulse(W'(i), 3, 1'b0, 1'b0);
    pulse(4'h6, 3, 1'b1, 1'b0);
    drain(4);

    // empty plus simultaneous capture and read
    pulse(4'h9, 3, 1'b1, 1'b0);
    drain(1);

    // pointer wrap: count oscillates 0..2
    for (int i = 0; i < 10; i += 2) begin
      pulse(W'(i), 3, 1'b0, 1'b0);
      pulse(W'(i + 1), 3, 1'b0, 1'b0);
      drain(2);
    end

    // reset mid-stream with three entries held
    pulse(4'h3, 3, 1'b0, 1'b0);
    pulse(4'h4, 3, 1'b0, 1'b0);
    pulse(4'h5, 3, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b1, 1'b0);
    reset = 1'b0;
    idle(3);

    // random strobes, reads and clears
    rnd_rd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      pulse(W'($urandom_range(0, 15)), $urandom_range(1, 4), 1'b0, 1'b0);
    end
    rnd_rd = 1'b0;
    drain(D + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
